// File: rtl/pt_check_pkg.sv
// Shared types and helpers for the plaintext printability checker.
// Used by pt_check and by crack's tests.
package pt_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LEN,
      SCAN_ARM,
      SCAN
   } pt_state_t;

   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/pt_check.sv
// Scans the length-prefixed plaintext memory for printable ASCII.
// Define PT_CHECK_EARLY_EXIT_EN to stop at the first bad byte.
module pt_check
   import pt_check_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic       pass,
   output logic [7:0] fail_idx
);

   pt_state_t  state;
   pt_state_t  nxt_state;
   logic [7:0] len;
   logic [7:0] nxt_len;
   logic [7:0] idx;
   logic [7:0] nxt_idx;
   logic [7:0] nxt_addr;
   logic       nxt_pass;
   logic [7:0] nxt_fail;
   logic       bad;
   logic       last;
   logic       done;

   assign rdy  = (state == IDLE);
   assign bad  = !is_printable(pt_rddata);
   assign last = (idx == len);

   // idx tracks the byte under test separately so the
   // address counter can saturate at 255 without wrapping
`ifdef PT_CHECK_EARLY_EXIT_EN
   assign done = last || bad;
`else
   assign done = last;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= 8'd0;
         idx      <= 8'd0;
         pt_addr  <= 8'd0;
         pass     <= 1'b0;
         fail_idx <= 8'd0;
      end else begin
         state    <= nxt_state;
         len      <= nxt_len;
         idx      <= nxt_idx;
         pt_addr  <= nxt_addr;
         pass     <= nxt_pass;
         fail_idx <= nxt_fail;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_len   = len;
      nxt_idx   = idx;
      nxt_addr  = pt_addr;
      nxt_pass  = pass;
      nxt_fail  = fail_idx;
      unique case (state)
         IDLE: begin
            if (en) begin
               nxt_pass  = 1'b0;
               nxt_fail  = 8'd0;
               nxt_addr  = 8'd0;
               nxt_idx   = 8'd0;
               nxt_state = LEN;
            end
         end
         LEN: begin
            nxt_addr  = 8'd1;
            nxt_state = SCAN_ARM;
         end
         SCAN_ARM: begin
            nxt_len = pt_rddata;
            if (pt_rddata == 8'd0) begin
               nxt_pass  = 1'b1;
               nxt_state = IDLE;
            end else begin
               nxt_addr  = 8'd2;
               nxt_idx   = 8'd1;
               nxt_state = SCAN;
            end
         end
         SCAN: begin
            if (bad && (fail_idx == 8'd0)) begin
               nxt_fail = idx;
            end
            if (pt_addr != 8'hFF) begin
               nxt_addr = pt_addr + 8'd1;
            end
            nxt_idx = idx + 8'd1;
            if (done) begin
               nxt_pass  = !bad && (fail_idx == 8'd0);
               nxt_idx   = idx;
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pt_check.sv
// Self-checking bench for pt_check: scan-level model plus
// directed plaintext vectors with hand-computed latencies.
module tb_pt_check;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic [7:0] pt_addr;
   logic [7:0] pt_rddata;
   logic       pass;
   logic [7:0] fail_idx;

   logic [7:0] mem [256];

   int tests;
   int fails;
   logic chk;
   logic seen;

   logic       m_rdy;
   logic       m_pass;
   logic [7:0] m_fail;
   logic       r_pass;
   logic [7:0] r_fail;
   int         m_cnt;

   pt_check dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .pass      (pass),
      .fail_idx  (fail_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pt_rddata <= mem[pt_addr];

   // first non-printable index of the current memory image
   function automatic logic [7:0] m_first();
      logic [7:0] f;
      int l;
      f = 8'd0;
      l = int'(mem[0]);
      for (int i = 1; i <= l; i++) begin
         if (f == 8'd0 && (mem[i] < 8'h20 || mem[i] > 8'h7E))
            f = 8'(i);
      end
      return f;
   endfunction

   // edges after the start edge until rdy is seen
   function automatic int m_lat();
      int e;
      e = int'(mem[0]);
`ifdef PT_CHECK_EARLY_EXIT_EN
      if (m_first() != 8'd0) e = int'(m_first());
`endif
      return 2 + e;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_rdy  <= 1'b1;
         m_pass <= 1'b0;
         m_fail <= 8'd0;
         m_cnt  <= 0;
      end else if (m_rdy) begin
         if (en) begin
            m_rdy  <= 1'b0;
            m_pass <= 1'b0;
            m_fail <= 8'd0;
            m_cnt  <= m_lat();
            r_fail <= m_first();
            r_pass <= (m_first() == 8'd0);
         end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_rdy  <= 1'b1;
            m_pass <= r_pass;
            m_fail <= r_fail;
         end
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic load_str(input string s);
      mem[0] = 8'(s.len());
      for (int i = 0; i < s.len(); i++) mem[i+1] = s[i];
   endtask

   task automatic run(input string nm, input int cyc,
                      input int ep, input int ef);
      int n;
      @(posedge clk);
      #1 en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      n = 1;
      @(negedge clk);
      while (!rdy && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({nm, " cycle"}, n, cyc);
      check({nm, " pass"}, int'(pass), ep);
      check({nm, " fail_idx"}, int'(fail_idx), ef);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while (!rdy && k < 400) begin
         @(negedge clk);
         k++;
      end
      check(nm, int'(rdy), 1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      chk   = 1'b0;
      seen  = 1'b0;
      rst_n = 1'b0;
      en    = 1'b0;
      fill(8'h00);
      fork
         forever begin
            @(negedge clk);
            if (chk) begin
               check("rdy", int'(rdy), int'(m_rdy));
               if (m_rdy) begin
                  check("pass", int'(pass), int'(m_pass));
                  check("fail_idx", int'(fail_idx), int'(m_fail));
               end else begin
                  check("busy pass", int'(pass), 0);
               end
               if (!m_rdy && seen)
                  check("addr wrap", int'(pt_addr == 8'd0), 0);
               seen = !m_rdy && (seen || pt_addr != 8'd0);
            end
         end
         begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check("reset rdy", int'(rdy), 1);
            check("reset pass", int'(pass), 0);
            check("reset fail_idx", int'(fail_idx), 0);
            check("reset pt_addr", int'(pt_addr), 0);
            chk = 1'b1;

            load_str("Hello");
            run("hello", 8, 1, 0);

            load_str("abXc");
            mem[3] = 8'h07;
`ifdef PT_CHECK_EARLY_EXIT_EN
            run("bel", 6, 0, 3);
`else
            run("bel", 7, 0, 3);
`endif

            mem[0] = 8'd0;
            run("empty", 3, 1, 0);

            mem[0] = 8'd3;
            mem[1] = 8'h20;
            mem[2] = 8'h7E;
            mem[3] = 8'h41;
            run("edges ok", 6, 1, 0);

            mem[0] = 8'd2;
            mem[1] = 8'h1F;
            mem[2] = 8'h7F;
`ifdef PT_CHECK_EARLY_EXIT_EN
            run("edges bad", 4, 0, 1);
`else
            run("edges bad", 5, 0, 1);
`endif

            load_str("xy?");
            mem[3] = 8'h80;
            run("high bit", 6, 0, 3);

            fill("A");
            mem[0] = 8'd255;
            run("full", 258, 1, 0);
            check("full last addr", int'(pt_addr), 255);

            @(posedge clk);
            #1 en = 1'b1;
            @(posedge clk);
            #1 en = 1'b0;
            repeat (10) @(posedge clk);
            #1 en = 1'b1;
            @(posedge clk);
            #1 en = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check("mid rst rdy", int'(rdy), 1);
            check("mid rst pass", int'(pass), 0);
            check("mid rst fail_idx", int'(fail_idx), 0);
            check("mid rst pt_addr", int'(pt_addr), 0);
            repeat (20) @(negedge clk);
            check("mid rst idle", int'(rdy), 1);

            load_str("Z");
            @(posedge clk);
            #1 en = 1'b1;
            repeat (14) @(posedge clk);
            #1 en = 1'b0;
            wait_idle("b2b idle");
            check("b2b pass", int'(pass), 1);
            repeat (3) @(negedge clk);
         end
      join_any
      disable fork;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pt_check.md
# pt_check

Plaintext validity checker for the RC4 key-cracking datapath. After the ARC4 core writes a candidate plaintext into the length-prefixed plaintext memory, `pt_check` scans it and reports whether every message byte is printable ASCII (8'h20..8'h7E). `crack` consumes its verdict to decide whether to assert `key_valid` or advance to the next 24-bit key. It uses the same `en`/`rdy` handshake as the other lab stages.

## Interface
- No parameters; the memory is fixed at 256 × 8 bits.
- `clk  in  1` — single clock for all logic.
- `rst_n  in  1` — reset, synchronous, active-low.
- `en  in  1` — start request; acted on only when `rdy`=1.
- `rdy  out  1` — 1 when idle and results are valid; 0 while scanning.
- `pt_addr  out  8` — plaintext memory read address (registered).
- `pt_rddata  in  8` — plaintext memory read data; valid one cycle after `pt_addr`.
- `pass  out  1` — 1 if all `len` bytes are printable (`len`=0 counts as pass).
- `fail_idx  out  8` — index (1..255) of the first non-printable byte; 0 when `pass`=1.

## Operation
- Memory layout: `mem[0]` = length L; message bytes are in `mem[1..L]`.
- States:
  - IDLE: `rdy`=1. When `en`=1, clear `pass`/`fail_idx`, set `pt_addr`←0, and go to LEN.
  - LEN: wait for the length byte; set `pt_addr`←1 and go to SCAN_ARM.
  - SCAN_ARM: latch `len`←`pt_rddata`.
    - If `len`=0: set `pass`←1 and go to IDLE.
    - Otherwise: set `pt_addr`←2 and go to SCAN.
  - SCAN: check `pt_rddata` for byte index i (i = `pt_addr`−1).
    - Issue one address per cycle (pipelined).
    - On the first non-printable byte, record `fail_idx`←i and hold it thereafter.
    - When i = L: set `pass`←(no failure recorded) and go to IDLE.
- Printable test: `8'h20 <= b <= 8'h7E`, unsigned compare. Bytes 8'h7F and ≥8'h80 fail.
- `en` while `rdy`=0 is ignored. `en` held high in IDLE starts back-to-back scans.
- `pt_addr` is 8-bit with no wrap. At L=255 the last address issued is 255 and the pipeline stops without wrapping to 0.
- Reads past L (one trailing address) are harmless and their data is ignored.
- Reset mid-scan: the next edge with `rst_n`=0 returns to IDLE with reset values. The partial result is discarded.

## Timing
- Reset values: `rdy`=1, `pass`=0, `fail_idx`=0, `pt_addr`=0, state IDLE.
- Cycle 0 is the edge that samples `en`=1 with `rdy`=1.
  - Cycle 1: `rdy`=0, `pt_addr`=0.
  - Cycle 2: `pt_rddata`=L.
  - Byte i is checked in cycle 2+i.
- Full-scan latency: `rdy` rises and `pass`/`fail_idx` are valid at cycle 3+L.
  - L=0 → cycle 3.
  - L=255 → cycle 258.
- Results are stable from `rdy`↑ until the next accepted `en`.

## Configuration
- `PT_CHECK_EARLY_EXIT_EN` defined: the scan terminates at the first failing byte i.
  - `rdy`=1 and `pass`=0 at cycle 3+i.
  - `fail_idx`=i.
- Not defined: the scan always completes all L bytes.
  - Latency is exactly 3+L regardless of content.
  - `fail_idx` still reports the first failing byte.
- `crack` throughput depends on this macro; the interface is identical either way.

## Structure
- Package `pt_check_pkg` holds:
  - the state enum `pt_state_t` (IDLE, LEN, SCAN_ARM, SCAN);
  - constants `PRINT_LO`=8'h20 and `PRINT_HI`=8'h7E;
  - the function `is_printable(logic [7:0])`, shared with `crack`'s tests.
- No sub-module: a single FSM plus the address counter and `len` register.

## Test plan
- After reset: `rdy`=1, `pass`=0, `fail_idx`=0, `pt_addr`=0.
- `mem` = {5,"Hello"}, pulse `en` → `rdy`=1 at cycle 8, `pass`=1, `fail_idx`=0.
- `mem` = {4,'a','b',8'h07,'c'}:
  - with the macro → `rdy` at cycle 6, `pass`=0, `fail_idx`=3;
  - without the macro → `rdy` at cycle 7, same results.
- `mem[0]`=0 → `rdy` at cycle 3, `pass`=1.
- Boundary bytes:
  - {3,8'h20,8'h7E,8'h41} → `pass`=1.
  - {2,8'h1F,8'h7F} → `fail_idx`=1.
- L=255 of 'A' → `rdy` at cycle 258, `pass`=1, `pt_addr` never wraps to 0.
- Reset mid-scan, with a second `en` pulsed while busy → return to reset values, no spurious result.
